uart_bootloader: RTL and testbench
==================================

Name: uart_bootloader

Overview:
Loader that sits upstream of the core's 16-bit instruction BRAM port and of the core reset. It takes a framed program image from the UART byte interface and assembles little-endian 16-bit words. It writes those words into instruction memory from word address 0 upward, and holds the core in reset until a frame passes its checksum. It answers each frame with a one-byte ACK or NAK on the UART transmit side.

Parameters:
MEM_ADDR_BITS, 9, word-address width of the instruction BRAM; maximum image is 2^MEM_ADDR_BITS words.
DATA_WIDTH, 16, memory word width; fixed at 16, with two bytes per word.
TIMEOUT_CYCLES, 24'd12_000_000, idle-byte limit inside a frame before the frame is aborted.
MAGIC, 8'hA5, frame start byte.

Ports:
clk_i  input  1  system clock
reset_ni  input  1  asynchronous, active-low reset
rx_valid_i  input  1  one-cycle strobe: rx_data_i holds a new received byte
rx_data_i  input  8  received byte
tx_ready_i  input  1  UART transmitter can accept a byte this cycle
tx_write_o  output  1  request to send tx_data_o
tx_data_o  output  8  response byte
mem_write_o  output  1  one-cycle BRAM write strobe
mem_addr_o  output  MEM_ADDR_BITS  word address of the write
mem_data_o  output  16  word to write, {high byte, low byte}
core_reset_o  output  1  1 holds the core in reset
done_o  output  1  image loaded and verified
error_o  output  1  sticky: last frame failed; cleared by the next MAGIC

Behaviour:
- Clock and reset: one clock, clk_i. Reset is asynchronous and active-low (reset_ni).
- Reset values:
  - tx_write_o=0, tx_data_o=0, mem_write_o=0, mem_addr_o=0, mem_data_o=0.
  - core_reset_o=1, done_o=0, error_o=0.
  - State=IDLE; checksum, length, word counter and timeout counter all 0.
- Frame format: MAGIC, LEN_LO, LEN_HI, then LEN words each sent as low byte then high byte, then CSUM.
  - CSUM is the 8-bit modulo-256 sum of the payload bytes only.
- States: IDLE, LEN_LO, LEN_HI, DATA_LO, DATA_HI, CHECK, RESP, DONE.
- IDLE:
  - A byte equal to MAGIC moves to LEN_LO, clears error_o, and clears the checksum and word counter.
  - Any other byte is ignored.
- LEN_LO: latch the low length byte, then go to LEN_HI.
- LEN_HI: latch the high length byte.
  - LEN=0: go to CHECK.
  - LEN>2^MEM_ADDR_BITS: fail.
  - Otherwise: go to DATA_LO.
- DATA_LO: latch the byte and add it to the checksum, then go to DATA_HI.
- DATA_HI: add the byte to the checksum.
  - In the cycle after the byte arrives: mem_write_o=1 for exactly one cycle, mem_addr_o=word counter, mem_data_o={byte, latched low byte}.
  - Increment the word counter.
  - If the counter now equals LEN, go to CHECK; otherwise go to DATA_LO.
  - Write latency is 1 cycle from rx_valid_i of the high byte.
- CHECK: compare the received byte with the checksum.
  - Equal: pass, tx_data_o=8'h4B.
  - Not equal: fail, tx_data_o=8'h4E.
  - Either way, go to RESP.
- Fail from any state: set error_o=1, tx_data_o=8'h4E, go to RESP.
- RESP:
  - tx_write_o holds 1 until a cycle with tx_ready_i=1; that cycle completes the transfer and tx_write_o drops the next cycle.
  - After a pass: go to DONE, drop core_reset_o to 0, set done_o to 1.
  - After a fail: go to IDLE with core_reset_o still 1.
  - rx_valid_i is ignored while in RESP.
- DONE: terminal until reset; all rx bytes are ignored and all outputs are held.
- Timeout: in LEN_LO through CHECK, the counter clears on every rx_valid_i and increments otherwise. On reaching TIMEOUT_CYCLES-1, fail. The counter is 0 in all other states.
- Partial images: words already written by a failed frame stay in BRAM. A retry overwrites from address 0.
- Reset mid-frame: asynchronous return to the reset values. core_reset_o reasserts immediately and no further write is issued.
- A byte with rx_valid_i in the same cycle as a timeout: the timeout wins and the byte is dropped.
- Word counter width is MEM_ADDR_BITS+1 so that LEN=2^MEM_ADDR_BITS is reachable without wrap.

Test Plan:
- Good frame A5 02 00 13 00 6F 00 82: expect writes (addr 0, 16'h0013) and (addr 1, 16'h006F); tx byte 4B; core_reset_o falls; done_o=1.
- Same frame with CSUM=00: no release; tx byte 4E; error_o=1; core_reset_o stays 1. A following good frame then passes and clears error_o.
- Length A5 01 02 (LEN=513) with MEM_ADDR_BITS=9: immediate 4E, no mem_write_o pulse.
- A5 00 00 00: zero-length frame passes; tx byte 4B; done_o=1; no writes.
- Timeout: with TIMEOUT_CYCLES=100, send A5 01 then stall 100 cycles: 4E; back in IDLE; junk byte 3C is then ignored.
- Backpressure and reset: hold tx_ready_i=0 for 20 cycles in RESP, then expect exactly one tx transfer. Assert reset_ni low mid-DATA_HI and expect all outputs at their reset values asynchronously.

Source files
------------

// File: rtl/uart_bootloader.sv
// UART program loader: receives a framed, checksummed image, writes 16-bit words
// into instruction BRAM from address 0 and releases the core reset on a good frame.
module uart_bootloader #(
  parameter int          MEM_ADDR_BITS  = 9,
  parameter int          DATA_WIDTH     = 16,
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd12_000_000,
  parameter logic [7:0]  MAGIC          = 8'hA5
) (
  input  logic                     clk_i,
  input  logic                     reset_ni,
  input  logic                     rx_valid_i,
  input  logic [7:0]               rx_data_i,
  input  logic                     tx_ready_i,
  output logic                     tx_write_o,
  output logic [7:0]               tx_data_o,
  output logic                     mem_write_o,
  output logic [MEM_ADDR_BITS-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0]    mem_data_o,
  output logic                     core_reset_o,
  output logic                     done_o,
  output logic                     error_o
);

  typedef enum logic [2:0] {
    IDLE, LEN_LO, LEN_HI, DATA_LO, DATA_HI, CHECK, RESP, DONE
  } state_t;

  localparam logic [16:0] MAX_LEN = 17'd1 << MEM_ADDR_BITS;
  localparam logic [7:0]  ACK     = 8'h4B;
  localparam logic [7:0]  NAK     = 8'h4E;

  state_t                 state;
  logic [7:0]             csum;
  logic [7:0]             len_lo;
  logic [7:0]             data_lo;
  logic [MEM_ADDR_BITS:0] len;
  logic [MEM_ADDR_BITS:0] word_cnt;
  logic [23:0]            tmo_cnt;
  logic                   pass;

  logic                   timed;
  logic                   tmo_hit;
  logic                   len_bad;
  logic                   sum_bad;
  logic                   fail;
  logic [16:0]            full_len;
  logic [MEM_ADDR_BITS:0] word_next;

  assign timed     = (state == LEN_LO) || (state == LEN_HI) || (state == DATA_LO) ||
                     (state == DATA_HI) || (state == CHECK);
  assign tmo_hit   = timed && (tmo_cnt == TIMEOUT_CYCLES - 24'd1);
  assign full_len  = {1'b0, rx_data_i, len_lo};
  assign len_bad   = (state == LEN_HI) && rx_valid_i && (full_len > MAX_LEN);
  assign sum_bad   = (state == CHECK) && rx_valid_i && (rx_data_i != csum);
  // A timeout takes priority over a byte arriving in the same cycle.
  assign fail      = tmo_hit || len_bad || sum_bad;
  assign word_next = word_cnt + {{MEM_ADDR_BITS{1'b0}}, 1'b1};

  // Frame FSM with registered memory, response and core-control outputs.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state        <= IDLE;
      csum         <= 8'd0;
      len_lo       <= 8'd0;
      data_lo      <= 8'd0;
      len          <= '0;
      word_cnt     <= '0;
      tmo_cnt      <= 24'd0;
      pass         <= 1'b0;
      tx_write_o   <= 1'b0;
      tx_data_o    <= 8'd0;
      mem_write_o  <= 1'b0;
      mem_addr_o   <= '0;
      mem_data_o   <= '0;
      core_reset_o <= 1'b1;
      done_o       <= 1'b0;
      error_o      <= 1'b0;
    end else begin
      mem_write_o <= 1'b0;
      tmo_cnt     <= (timed && !rx_valid_i && !fail) ? tmo_cnt + 24'd1 : 24'd0;
      if (fail) begin
        error_o    <= 1'b1;
        tx_data_o  <= NAK;
        tx_write_o <= 1'b1;
        pass       <= 1'b0;
        state      <= RESP;
      end else begin
        case (state)
          IDLE: begin
            if (rx_valid_i && (rx_data_i == MAGIC)) begin
              state    <= LEN_LO;
              error_o  <= 1'b0;
              csum     <= 8'd0;
              word_cnt <= '0;
            end
          end
          LEN_LO: begin
            if (rx_valid_i) begin
              len_lo <= rx_data_i;
              state  <= LEN_HI;
            end
          end
          LEN_HI: begin
            if (rx_valid_i) begin
              len   <= full_len[MEM_ADDR_BITS:0];
              state <= (full_len == 17'd0) ? CHECK : DATA_LO;
            end
          end
          DATA_LO: begin
            if (rx_valid_i) begin
              data_lo <= rx_data_i;
              csum    <= csum + rx_data_i;
              state   <= DATA_HI;
            end
          end
          DATA_HI: begin
            if (rx_valid_i) begin
              csum        <= csum + rx_data_i;
              mem_write_o <= 1'b1;
              mem_addr_o  <= word_cnt[MEM_ADDR_BITS-1:0];
              mem_data_o  <= {rx_data_i, data_lo};
              word_cnt    <= word_next;
              state       <= (word_next == len) ? CHECK : DATA_LO;
            end
          end
          CHECK: begin
            if (rx_valid_i) begin
              pass       <= 1'b1;
              tx_data_o  <= ACK;
              tx_write_o <= 1'b1;
              state      <= RESP;
            end
          end
          RESP: begin
            if (tx_ready_i) begin
              tx_write_o <= 1'b0;
              if (pass) begin
                state        <= DONE;
                core_reset_o <= 1'b0;
                done_o       <= 1'b1;
              end else begin
                state <= IDLE;
              end
            end
          end
          DONE: begin
            state <= DONE;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_bootloader.sv
// Scoreboard bench for uart_bootloader: a frame-level model queues the expected
// BRAM writes and response bytes; a monitor pops and compares them as they appear.
module tb_uart_bootloader;

  localparam int MAX_WORDS = 512;

  logic        clk = 1'b0;
  logic        reset_ni;
  logic        rx_valid_i;
  logic [7:0]  rx_data_i;
  logic        tx_ready_i;
  logic        tx_write_o;
  logic [7:0]  tx_data_o;
  logic        mem_write_o;
  logic [8:0]  mem_addr_o;
  logic [15:0] mem_data_o;
  logic        core_reset_o;
  logic        done_o;
  logic        error_o;

  int total = 0;
  int bad   = 0;

  int          exp_wa[$];
  logic [15:0] exp_wd[$];
  logic [7:0]  exp_tx[$];
  logic [15:0] payload[$];

  always #5 clk = ~clk;

  uart_bootloader #(
    .MEM_ADDR_BITS (9),
    .DATA_WIDTH    (16),
    .TIMEOUT_CYCLES(24'd100),
    .MAGIC         (8'hA5)
  ) dut (
    .clk_i       (clk),
    .reset_ni    (reset_ni),
    .rx_valid_i  (rx_valid_i),
    .rx_data_i   (rx_data_i),
    .tx_ready_i  (tx_ready_i),
    .tx_write_o  (tx_write_o),
    .tx_data_o   (tx_data_o),
    .mem_write_o (mem_write_o),
    .mem_addr_o  (mem_addr_o),
    .mem_data_o  (mem_data_o),
    .core_reset_o(core_reset_o),
    .done_o      (done_o),
    .error_o     (error_o)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every write pulse and every completed tx transfer must match the queue head.
  always @(negedge clk) begin
    if (reset_ni) begin
      if (mem_write_o) begin
        if (exp_wa.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_write: got addr %0d data %h expected none", mem_addr_o, mem_data_o);
        end else begin
          check("write_addr", 64'(mem_addr_o), 64'(exp_wa.pop_front()));
          check("write_data", 64'(mem_data_o), 64'(exp_wd.pop_front()));
        end
      end
      if (tx_write_o && tx_ready_i) begin
        if (exp_tx.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_tx: got %h expected none", tx_data_o);
        end else begin
          check("tx_byte", 64'(tx_data_o), 64'(exp_tx.pop_front()));
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    rx_data_i  = b;
    rx_valid_i = 1'b1;
    tick(1);
    rx_valid_i = 1'b0;
    tick($urandom_range(0, 2));
  endtask

  task automatic do_reset();
    reset_ni = 1'b0;
    tick(2);
    reset_ni = 1'b1;
    tick(1);
  endtask

  task automatic wait_tx(input string name, input int budget);
    int n = 0;
    while (exp_tx.size() != 0 && n < budget) begin
      tick(1);
      n++;
    end
    check({name, "_response_seen"}, 64'(exp_tx.size()), 64'd0);
    check({name, "_writes_done"}, 64'(exp_wa.size()), 64'd0);
    exp_tx.delete(); exp_wa.delete(); exp_wd.delete();
    tick(2);
  endtask

  task automatic flags(input string name, input logic cr, input logic dn, input logic er);
    check({name, "_flags"}, 64'({core_reset_o, done_o, error_o}), 64'({cr, dn, er}));
  endtask

  function automatic logic [7:0] psum();
    int s = 0;
    foreach (payload[i]) s += int'(payload[i][7:0]) + int'(payload[i][15:8]);
    return 8'(s);
  endfunction

  task automatic fill(input int len);
    payload.delete();
    for (int i = 0; i < len; i++) payload.push_back(16'($urandom));
  endtask

  // Frame model: oversize lengths are NAKed after the header with no writes;
  // otherwise every word is written in order and the reply depends on the byte sum.
  task automatic frame(input int len, input logic [7:0] csum);
    if (len > MAX_WORDS) begin
      exp_tx.push_back(8'h4E);
      send(8'hA5); send(8'(len)); send(8'(len >> 8));
    end else begin
      for (int i = 0; i < len; i++) begin
        exp_wa.push_back(i);
        exp_wd.push_back(payload[i]);
      end
      exp_tx.push_back((csum == psum()) ? 8'h4B : 8'h4E);
      send(8'hA5); send(8'(len)); send(8'(len >> 8));
      for (int i = 0; i < len; i++) begin
        send(payload[i][7:0]);
        send(payload[i][15:8]);
      end
      send(csum);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int len;
    reset_ni   = 1'b0;
    rx_valid_i = 1'b0;
    rx_data_i  = 8'd0;
    tx_ready_i = 1'b1;
    tick(2);
    check("rst_ctrl", 64'({tx_write_o, mem_write_o, core_reset_o, done_o, error_o}), 64'(5'b00100));
    check("rst_data", 64'({tx_data_o, mem_addr_o, mem_data_o}), 64'd0);
    reset_ni = 1'b1;
    tick(1);

    // Known frame with a zero checksum byte: words written, NAK, core held.
    payload = '{16'h0013, 16'h006F};
    frame(2, 8'h00);
    wait_tx("bad_csum", 50);
    flags("bad_csum", 1'b1, 1'b0, 1'b1);

    // LEN = 513 is one past the memory size.
    payload.delete();
    frame(513, 8'h00);
    wait_tx("oversize", 50);
    flags("oversize", 1'b1, 1'b0, 1'b1);

    // Stall inside the length field until the timeout fires.
    exp_tx.push_back(8'h4E);
    send(8'hA5); send(8'h01);
    tick(90);
    check("timeout_not_early", 64'(exp_tx.size()), 64'd1);
    wait_tx("timeout", 40);
    flags("timeout", 1'b1, 1'b0, 1'b1);
    send(8'h3C);
    tick(20);
    flags("junk_ignored", 1'b1, 1'b0, 1'b1);

    // Random failing frames, including random oversize lengths.
    for (int k = 0; k < 6; k++) begin
      if (k == 5) begin
        payload.delete();
        frame($urandom_range(MAX_WORDS + 1, 65535), 8'h00);
      end else begin
        len = $urandom_range(1, 8);
        fill(len);
        frame(len, psum() + 8'($urandom_range(1, 255)));
      end
      wait_tx("rand_bad", 60);
      flags("rand_bad", 1'b1, 1'b0, 1'b1);
    end

    // Good frame under transmit backpressure; also clears the sticky error.
    payload = '{16'h0013, 16'h006F};
    tx_ready_i = 1'b0;
    frame(2, 8'h82);
    tick(20);
    check("bp_hold_write", 64'(tx_write_o), 64'd1);
    check("bp_no_early_tx", 64'(exp_tx.size()), 64'd1);
    tx_ready_i = 1'b1;
    wait_tx("good", 20);
    flags("good", 1'b0, 1'b1, 1'b0);
    check("tx_write_dropped", 64'(tx_write_o), 64'd0);

    // DONE ignores any further traffic.
    send(8'hA5); send(8'h01); send(8'h00); send(8'h11); send(8'h22); send(8'h33);
    tick(10);
    flags("done_hold", 1'b0, 1'b1, 1'b0);

    do_reset();
    payload.delete();
    frame(0, 8'h00);
    wait_tx("zero_len", 30);
    flags("zero_len", 1'b0, 1'b1, 1'b0);

    for (int k = 0; k < 3; k++) begin
      do_reset();
      len = $urandom_range(1, 40);
      fill(len);
      frame(len, psum());
      wait_tx("rand_good", 60);
      flags("rand_good", 1'b0, 1'b1, 1'b0);
    end

    do_reset();
    fill(MAX_WORDS);
    frame(MAX_WORDS, psum());
    wait_tx("max_len", 60);
    flags("max_len", 1'b0, 1'b1, 1'b0);

    // Reset asserted while waiting for the high byte of word 1.
    do_reset();
    exp_wa.push_back(0);
    exp_wd.push_back(16'h2211);
    send(8'hA5); send(8'h02); send(8'h00); send(8'h11); send(8'h22); send(8'h33);
    tick(2);
    check("mid_write_seen", 64'(exp_wa.size()), 64'd0);
    rx_data_i  = 8'h44;
    rx_valid_i = 1'b1;
    #2 reset_ni = 1'b0;
    #1;
    check("async_rst_ctrl", 64'({tx_write_o, mem_write_o, core_reset_o, done_o, error_o}), 64'(5'b00100));
    check("async_rst_data", 64'({tx_data_o, mem_addr_o, mem_data_o}), 64'd0);
    rx_valid_i = 1'b0;
    tick(3);
    reset_ni = 1'b1;
    tick(20);
    flags("after_rst", 1'b1, 1'b0, 1'b0);

    check("queues_drained", 64'(exp_wa.size() + exp_tx.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
